// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
//   Responder side of an HD44780-style character-LCD bus. Snoops E/RS/RW/DB,
//   executes instructions and data writes into a 2x16 display buffer, keeps
//   the DDRAM address counter and display flags, and reports busy.
//
// Ports
//   clk         system clock, all logic on posedge
//   resetn      asynchronous active-low reset
//   lcde        LCD enable strobe (asynchronous to clk)
//   lcdrs       register select: 0 = instruction/status, 1 = data
//   lcdrw       1 = read, 0 = write
//   lcddata     bus data from the controller
//   lcddout     read data returned to the controller
//   lcddout_en  high while a read is being returned
//   rd_addr     side-port address: 0-15 line 1, 16-31 line 2
//   rd_data     buffer[rd_addr], combinational
//   busy        command executing
//   ac          DDRAM address counter
//   disp_on, cursor_on, blink_on  display-control flags
//   drop_err    sticky: a transaction arrived while busy and was dropped
module lcd_bus_responder #(
  parameter int BUSY_CYCLES  = 4,
  parameter int CLEAR_CYCLES = 40
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lcde,
  input  logic       lcdrs,
  input  logic       lcdrw,
  input  logic [7:0] lcddata,
  output logic [7:0] lcddout,
  output logic       lcddout_en,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       drop_err
);

  localparam logic [15:0] BUSY_LOAD  = 16'(BUSY_CYCLES - 1);
  localparam logic [15:0] CLEAR_LOAD = 16'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_CLEAR} state_t;

  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n;
  logic [5:0]  r_clr_idx, w_clr_idx_n;

  // Bus synchronisers and strobe edge detect
  logic       r_e_s1, r_e_s, r_e_d;
  logic       r_rs_s1, r_rs_s, r_rw_s1, r_rw_s;
  logic [7:0] r_d_s1, r_d_s;
  logic       r_h_rs, r_h_rw;
  logic [7:0] r_h_d;

  logic [6:0] r_ac, w_ac_n;
  logic       r_id, w_id_n, r_sh, w_sh_n;
  logic       r_dl, w_dl_n, r_n, w_n_n, r_f, w_f_n;
  logic       r_cg, w_cg_n;
  logic       r_disp, w_disp_n, r_cur, w_cur_n, r_blink, w_blink_n;
  logic       r_drop, w_drop_n;

  logic [7:0] r_buf [32];
  logic       w_wr_en;
  logic [4:0] w_wr_idx;
  logic [7:0] w_wr_data;

  logic       w_fire, w_status, w_ac_vis, w_exec;
  logic [4:0] w_ac_idx;
  logic [7:0] w_ac_rd;

  // Entry-mode shift and function-set bits are held but not modelled.
  logic w_unused;
  assign w_unused = ^{r_sh, r_dl, r_n, r_f};

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) r = (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
    else    r = (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_e_s1  <= 1'b0; r_e_s  <= 1'b0; r_e_d <= 1'b0;
      r_rs_s1 <= 1'b0; r_rs_s <= 1'b0;
      r_rw_s1 <= 1'b0; r_rw_s <= 1'b0;
      r_d_s1  <= '0;   r_d_s  <= '0;
      r_h_rs  <= 1'b0; r_h_rw <= 1'b0; r_h_d <= '0;
    end else begin
      r_e_s1  <= lcde;    r_e_s  <= r_e_s1;  r_e_d <= r_e_s;
      r_rs_s1 <= lcdrs;   r_rs_s <= r_rs_s1;
      r_rw_s1 <= lcdrw;   r_rw_s <= r_rw_s1;
      r_d_s1  <= lcddata; r_d_s  <= r_d_s1;
      if (r_e_s) begin
        r_h_rs <= r_rs_s;
        r_h_rw <= r_rw_s;
        r_h_d  <= r_d_s;
      end
    end
  end

  assign w_fire   = ~r_e_s & r_e_d;
  assign w_status = ~r_h_rs & r_h_rw;
  // Visible windows 0x00-0x0F and 0x40-0x4F share bits [5:4] == 0.
  assign w_ac_vis = (r_ac[5:4] == 2'b00);
  assign w_ac_idx = {r_ac[6], r_ac[3:0]};
  assign w_ac_rd  = w_ac_vis ? r_buf[w_ac_idx] : 8'h20;

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_cnt;
    w_clr_idx_n = r_clr_idx;
    w_ac_n      = r_ac;
    w_id_n      = r_id;
    w_sh_n      = r_sh;
    w_dl_n      = r_dl;
    w_n_n       = r_n;
    w_f_n       = r_f;
    w_cg_n      = r_cg;
    w_disp_n    = r_disp;
    w_cur_n     = r_cur;
    w_blink_n   = r_blink;
    w_drop_n    = r_drop;
    w_wr_en     = 1'b0;
    w_wr_idx    = w_ac_idx;
    w_wr_data   = r_h_d;
    w_exec      = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_fire && !w_status) begin
          if (!r_h_rs) begin
            casez (r_h_d)
              8'b1???????: begin
                w_ac_n = r_h_d[6:0];
                if (r_h_d[5:0] >= 6'h28) w_ac_n = r_h_d[6] ? 7'h00 : 7'h40;
                w_cg_n = 1'b0;
                w_exec = 1'b1;
              end
              8'b01??????: begin
                w_cg_n = 1'b1;
                w_exec = 1'b1;
              end
              8'b001?????: begin
                w_dl_n = r_h_d[4];
                w_n_n  = r_h_d[3];
                w_f_n  = r_h_d[2];
                w_exec = 1'b1;
              end
              8'b0001????: begin
                if (!r_h_d[3]) w_ac_n = ac_step(r_ac, r_h_d[2]);
                w_exec = 1'b1;
              end
              8'b00001???: begin
                w_disp_n  = r_h_d[2];
                w_cur_n   = r_h_d[1];
                w_blink_n = r_h_d[0];
                w_exec    = 1'b1;
              end
              8'b000001??: begin
                w_id_n = r_h_d[1];
                w_sh_n = r_h_d[0];
                w_exec = 1'b1;
              end
              8'b0000001?: begin
                w_ac_n = '0;
                w_exec = 1'b1;
              end
              8'b00000001: begin
                w_ac_n      = '0;
                w_id_n      = 1'b1;
                w_clr_idx_n = '0;
                w_cnt_n     = CLEAR_LOAD;
                w_state_n   = ST_CLEAR;
              end
              default: ;
            endcase
          end else if (!r_h_rw) begin
            // In CG mode a data write is ignored outright: no AC move, no busy.
            if (!r_cg) begin
              w_wr_en = w_ac_vis;
              w_ac_n  = ac_step(r_ac, r_id);
              w_exec  = 1'b1;
            end
          end else begin
            w_ac_n = ac_step(r_ac, r_id);
            w_exec = 1'b1;
          end
        end
      end
      ST_EXEC, ST_CLEAR: begin
        if (r_state == ST_CLEAR && !r_clr_idx[5]) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = r_clr_idx[4:0];
          w_wr_data   = 8'h20;
          w_clr_idx_n = r_clr_idx + 6'd1;
        end
        if (r_cnt == '0) w_state_n = ST_IDLE;
        else             w_cnt_n   = r_cnt - 16'd1;
        if (w_fire && !w_status) w_drop_n = 1'b1;
      end
      default: w_state_n = ST_IDLE;
    endcase

    if (w_exec) begin
      w_state_n = ST_EXEC;
      w_cnt_n   = BUSY_LOAD;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_clr_idx <= '0;
      r_ac      <= '0;
      r_id      <= 1'b1;
      r_sh      <= 1'b0;
      r_dl      <= 1'b0;
      r_n       <= 1'b0;
      r_f       <= 1'b0;
      r_cg      <= 1'b0;
      r_disp    <= 1'b0;
      r_cur     <= 1'b0;
      r_blink   <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_clr_idx <= w_clr_idx_n;
      r_ac      <= w_ac_n;
      r_id      <= w_id_n;
      r_sh      <= w_sh_n;
      r_dl      <= w_dl_n;
      r_n       <= w_n_n;
      r_f       <= w_f_n;
      r_cg      <= w_cg_n;
      r_disp    <= w_disp_n;
      r_cur     <= w_cur_n;
      r_blink   <= w_blink_n;
      r_drop    <= w_drop_n;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else if (w_wr_en) begin
      r_buf[w_wr_idx] <= w_wr_data;
    end
  end

  // Read data tracks the live state every cycle the strobe is high, so a
  // status read reflects busy/ac as of the last cycle before E falls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lcddout <= '0;
    else if (r_e_s) lcddout <= r_rs_s ? w_ac_rd : {busy, r_ac};
  end

  assign lcddout_en = r_e_s & r_rw_s;
  assign rd_data    = r_buf[rd_addr];
  assign busy       = (r_state != ST_IDLE);
  assign ac         = r_ac;
  assign disp_on    = r_disp;
  assign cursor_on  = r_cur;
  assign blink_on   = r_blink;
  assign drop_err   = r_drop;

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;

  localparam int BUSY = 4;
  localparam int CLR  = 40;

  logic       clk = 1'b0;
  logic       resetn;
  logic       lcde, lcdrs, lcdrw;
  logic [7:0] lcddata;
  logic [7:0] lcddout;
  logic       lcddout_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on, drop_err;

  lcd_bus_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLR)) dut (
    .clk(clk), .resetn(resetn), .lcde(lcde), .lcdrs(lcdrs), .lcdrw(lcdrw),
    .lcddata(lcddata), .lcddout(lcddout), .lcddout_en(lcddout_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: AC kept as a position on an 80-slot ring
  // (line 1 = 0..39, line 2 = 40..79).
  logic [7:0] mbuf [32];
  int  mpos;
  bit  mid, mcg, mdisp, mcur, mblink, mdrop;
  int  busy_last;
  int  last_g;
  logic [7:0] exp_q [$];

  function automatic int pos2ac(input int p);
    return (p < 40) ? p : 64 + (p - 40);
  endfunction

  function automatic int vis_idx(input int p);
    int col;
    col = p % 40;
    return (col < 16) ? (p / 40) * 16 + col : -1;
  endfunction

  function automatic int advance(input int p, input bit up);
    return up ? (p + 1) % 80 : (p + 79) % 80;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    mpos = 0; mid = 1; mcg = 0; mdisp = 0; mcur = 0; mblink = 0; mdrop = 0;
    busy_last = -10; last_g = -10;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // E was lowered after edge n: first low sample at k=n+1, fires at n+3.
  task automatic model_apply(input bit rs, input bit rw, input logic [7:0] d, input int n);
    int k, g, dur, vi, dv, a, low, line;
    bit bsy, executed;
    logic [6:0] a7;
    k = n + 1; g = n + 3; dv = int'(d);
    bsy = (k <= busy_last);
    a7 = 7'(pos2ac(mpos));
    if (rw) begin
      vi = vis_idx(mpos);
      if (rs) exp_q.push_back((vi >= 0) ? mbuf[vi] : 8'h20);
      else    exp_q.push_back({bsy, a7});
    end
    if (rw && !rs) return;
    last_g = g;
    if (g <= busy_last + 1) begin
      mdrop = 1;
      return;
    end
    dur = BUSY; executed = 1;
    if (!rs) begin
      if (dv == 0) executed = 0;
      else if (dv == 1) begin
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        mpos = 0; mid = 1; dur = CLR;
      end
      else if (dv < 4)   mpos = 0;
      else if (dv < 8)   mid = d[1];
      else if (dv < 16)  begin mdisp = d[2]; mcur = d[1]; mblink = d[0]; end
      else if (dv < 32)  begin if (!d[3]) mpos = advance(mpos, d[2]); end
      else if (dv < 64)  ;
      else if (dv < 128) mcg = 1;
      else begin
        a = dv % 128; low = a % 64; line = a / 64;
        mpos = (low >= 40) ? ((line + 1) % 2) * 40 : line * 40 + low;
        mcg = 0;
      end
    end else if (!rw) begin
      if (mcg) executed = 0;
      else begin
        vi = vis_idx(mpos);
        if (vi >= 0) mbuf[vi] = d;
        mpos = advance(mpos, mid);
      end
    end else begin
      mpos = advance(mpos, mid);
    end
    if (executed) busy_last = g + dur - 1;
  endtask

  task automatic txn(input bit rs, input bit rw, input logic [7:0] d, input int hold, input int gap);
    repeat (gap) @(negedge clk);
    lcdrs = rs; lcdrw = rw; lcddata = d; lcde = 1'b1;
    repeat (hold) @(negedge clk);
    lcde = 1'b0;
    model_apply(rs, rw, d, cyc);
  endtask

  task automatic settle();
    while (cyc <= busy_last || cyc < last_g) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_state();
    chk("ac", ac, pos2ac(mpos));
    chk("busy_idle", busy, 0);
    chk("disp_on", disp_on, mdisp);
    chk("cursor_on", cursor_on, mcur);
    chk("blink_on", blink_on, mblink);
    chk("drop_err", drop_err, mdrop);
  endtask

  task automatic sweep();
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      chk($sformatf("buf[%0d]", i), rd_data, mbuf[i]);
    end
  endtask

  function automatic logic [7:0] rand_instr();
    logic [7:0] r;
    r = 8'($urandom);
    case ($urandom_range(0, 8))
      0: return 8'h00;
      1: return ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h02;
      2: return 8'h02 | (r & 8'h01);
      3: return 8'h04 | (r & 8'h03);
      4: return 8'h08 | (r & 8'h07);
      5: return 8'h10 | (r & 8'h0F);
      6: return 8'h20 | (r & 8'h1F);
      7: return 8'h40 | (r & 8'h3F);
      default: return 8'h80 | r;
    endcase
  endfunction

  // Monitor: a returned read completes when lcddout_en drops.
  bit prev_en = 0;
  logic [7:0] mon_exp;
  always @(negedge clk) begin
    if (prev_en && !lcddout_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_unexpected got %02h expected none", lcddout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (lcddout !== mon_exp) begin
          errors++;
          $display("FAIL read_data got %02h expected %02h (cycle %0d)", lcddout, mon_exp, cyc);
        end
      end
    end
    prev_en = lcddout_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int kind, h, g;
    logic [7:0] d;
    resetn = 1'b0; lcde = 1'b0; lcdrs = 1'b0; lcdrw = 1'b0; lcddata = '0; rd_addr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_lcddout", lcddout, 0);
    chk("rst_lcddout_en", lcddout_en, 0);
    check_state();
    sweep();
    @(negedge clk);
    resetn = 1'b1;
    model_reset();

    // Init sequence and "THIS"
    txn(0, 0, 8'h38, 2, 50);
    txn(0, 0, 8'h0C, 2, 50);
    txn(0, 0, 8'h06, 2, 50);
    txn(0, 0, 8'h80, 2, 50);
    txn(1, 0, 8'h54, 2, 50);
    txn(1, 0, 8'h48, 2, 50);
    txn(1, 0, 8'h49, 2, 50);
    txn(1, 0, 8'h53, 2, 50);
    settle();
    rd_addr = 5'd0; #1; chk("this_0", rd_data, 8'h54);
    rd_addr = 5'd1; #1; chk("this_1", rd_data, 8'h48);
    rd_addr = 5'd2; #1; chk("this_2", rd_data, 8'h49);
    rd_addr = 5'd3; #1; chk("this_3", rd_data, 8'h53);
    chk("this_ac", ac, 7'h04);
    chk("this_disp", disp_on, 1);
    chk("this_cursor", cursor_on, 0);
    check_state();

    // End of visible line 1
    txn(0, 0, 8'h8F, 2, 10);
    txn(1, 0, 8'h41, 2, 10);
    settle();
    chk("wrap_ac_10", ac, 7'h10);
    txn(1, 0, 8'h42, 2, 10);
    settle();
    chk("wrap_ac_11", ac, 7'h11);
    rd_addr = 5'd15; #1; chk("wrap_buf15", rd_data, 8'h41);
    rd_addr = 5'd16; #1; chk("wrap_buf16", rd_data, 8'h20);

    // Clear with a status read during it
    txn(0, 0, 8'h01, 2, 10);
    txn(0, 1, 8'h00, 2, 3);
    repeat (2) @(negedge clk);
    chk("clear_status", lcddout, 8'h80);
    settle();
    chk("clear_busy_done", busy, 0);
    check_state();
    sweep();

    // Write too soon after a command
    chk("drop_before", drop_err, 0);
    txn(0, 0, 8'h0C, 2, 10);
    txn(1, 0, 8'h5A, 1, 2);
    settle();
    chk("drop_after", drop_err, 1);
    check_state();
    sweep();

    // Decrementing across line 2 start
    txn(0, 0, 8'h04, 2, 10);
    txn(0, 0, 8'hC0, 2, 10);
    txn(1, 0, 8'h58, 2, 10);
    settle();
    chk("dec_ac_27", ac, 7'h27);
    txn(1, 0, 8'h59, 2, 10);
    settle();
    rd_addr = 5'd16; #1; chk("dec_buf16", rd_data, 8'h58);
    chk("dec_ac_26", ac, 7'h26);
    check_state();
    sweep();

    // Reset in the middle of clear
    txn(0, 0, 8'h01, 2, 10);
    repeat (12) @(negedge clk);
    chk("mid_clear_busy", busy, 1);
    resetn = 1'b0;
    #1;
    model_reset();
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ac", ac, 0);
    chk("rst_mid_drop", drop_err, 0);
    chk("rst_mid_lcddout", lcddout, 0);
    sweep();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    settle();
    check_state();

    // Randomised traffic
    for (int t = 0; t < 300; t++) begin
      kind = $urandom_range(0, 99);
      h = $urandom_range(1, 4);
      g = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 20) : $urandom_range(2, 6);
      d = 8'($urandom_range(8'h20, 8'h7E));
      if (kind < 20)      txn(0, 1, d, h, g);
      else if (kind < 35) txn(1, 1, d, h, g);
      else if (kind < 65) txn(1, 0, d, h, g);
      else                txn(0, 0, rand_instr(), h, g);
      if (t % 25 == 24) begin
        settle();
        check_state();
        sweep();
      end
    end
    settle();
    check_state();
    sweep();
    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_responder.md
# lcd_bus_responder

- Responder end of the HD44780-style character-LCD bus (E/RS/RW/DB[7:0]) driven by our LCD controller blocks.
- Decodes instructions and data writes into an internal 2x16 display buffer, tracks the address counter (AC) and display flags, and emits the busy flag.
- The buffer is readable on a side port by downstream display/scan logic.
- Used as an on-chip display snooper and as the synthesizable LCD model in controller benches.

## Interface
Parameters:
- BUSY_CYCLES, 4: busy duration in clk cycles for every executed command except clear/no-op; must be ≥1.
- CLEAR_CYCLES, 40: busy duration for clear display; must be ≥32.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  asynchronous, active-low reset.
- lcde  in  1  LCD enable strobe, asynchronous to clk.
- lcdrs  in  1  register select: 0 = instruction/status, 1 = data.
- lcdrw  in  1  1 = read, 0 = write.
- lcddata  in  8  bus data from the controller.
- lcddout  out  8  read data returned to the controller.
- lcddout_en  out  1  high while a read is being returned.
- rd_addr  in  5  side-port address: 0–15 = line 1, 16–31 = line 2.
- rd_data  out  8  buffer[rd_addr], combinational from the buffer registers.
- busy  out  1  command executing.
- ac  out  7  current DDRAM address counter.
- disp_on, cursor_on, blink_on  out  1 each  display-control flags.
- drop_err  out  1  sticky: a transaction arrived while busy and was dropped.

## Operation
- lcde, lcdrs, lcdrw and lcddata pass through two flops each (e_s, rs_s, rw_s, d_s), plus one delay flop e_d on e_s.
- Hold registers capture rs_s/rw_s/d_s on every cycle while e_s = 1.
- A transaction fires on the cycle where e_s = 0 and e_d = 1, using the held values.
- States: IDLE, EXEC (busy countdown), CLEAR (buffer fill plus busy countdown).
- Transactions are accepted only in IDLE. A write or data read arriving in EXEC/CLEAR is discarded and sets drop_err.
- A status read (rs=0, rw=1) is serviced in any state and never sets busy.
- Instruction write (rs=0, rw=0), decoded by highest set bit of data:
  - 0x00: no-op, no busy.
  - 0x01 clear: every buffer entry = 0x20, AC = 0, id = 1; go to CLEAR.
  - 0x02–03 home: AC = 0.
  - 0x04–07 entry mode: id = bit1, sh = bit0 (sh stored only, display shift not modeled).
  - 0x08–0F: disp_on = bit2, cursor_on = bit1, blink_on = bit0.
  - 0x10–1F: if bit3 = 0, move AC by ±1 per bit2 (1 = +) using the wrap rules below; if bit3 = 1, no effect.
  - 0x20–3F function set: dl/n/f stored from bits 4/3/2.
  - 0x40–7F: set cg_mode; data writes are discarded while cg_mode = 1.
  - 0x80–FF: AC = data[6:0] and cg_mode = 0. Values 0x28–0x3F map to 0x40; values 0x68–0x7F map to 0x00.
  - Every executed command except 0x00 and clear goes to EXEC.
- Data write (rs=1, rw=0):
  - AC 0x00–0x0F writes buffer[AC]; AC 0x40–0x4F writes buffer[16+AC−0x40].
  - Other AC values: write discarded.
  - AC then advances per id; go to EXEC.
- Data read (rs=1, rw=1): lcddout = buffer at AC, or 0x20 if AC is not visible; AC advances per id; go to EXEC.
- AC wrap:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
- Status read: lcddout = {busy, ac}.
- lcddout_en = e_s & rw_s. lcddout updates every cycle while e_s = 1.

## Timing
- Reset values:
  - All buffer entries 0x20.
  - ac = 0, id = 1, cg_mode = 0.
  - disp_on = cursor_on = blink_on = 0.
  - busy = 0, drop_err = 0, state IDLE.
  - lcddout = 0x00, lcddout_en = 0.
- Latency: if lcde is first sampled low at clk edge k, the transaction fires at edge k+2. Its effects on ac, flags, buffer and busy are visible after edge k+2.
- busy rises on the firing edge and stays high for exactly BUSY_CYCLES cycles (EXEC) or CLEAR_CYCLES cycles (CLEAR).
- CLEAR writes one entry per cycle, index 0..31. ac = 0 on the firing edge.
- rd_data reflects a buffer write after the writing edge. A side-port read of the same address on that cycle returns the old value.
- resetn low mid-CLEAR or mid-EXEC: immediate return to reset values; no partial state is kept.

## Test plan
- Sequence 0x38, 0x0C, 0x06, 0x80, then data 'T','H','I','S' with 50-cycle gaps → rd_data[0..3] = 0x54,0x48,0x49,0x53; ac = 0x04; disp_on = 1, cursor_on = 0.
- Write 0x8F then data 'A','B' → buffer[15] = 0x41; ac wraps 0x10 then 0x11; 'B' discarded; buffer[16] stays 0x20.
- Write 0x01, then a status read 5 cycles later → lcddout = 0x80 (busy, ac = 0), lcddout_en = 1; after CLEAR_CYCLES all 32 entries = 0x20 and busy = 0.
- Data write issued 2 cycles after a 0x0C command (BUSY_CYCLES = 4) → write dropped, drop_err = 1, buffer unchanged.
- Entry mode 0x04, 0xC0, then two data writes → buffer[16] written; ac goes 0x40→0x27; second write discarded.
- Assert resetn low in the middle of CLEAR → busy = 0, ac = 0, state IDLE immediately; buffer reads back all 0x20.
